// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

  // funct3 access-size encodings as presented by the core
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    DRAIN
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_extract.sv
// Load data extraction: picks the addressed byte/half from a bus word and extends it.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension according to access size
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'd0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'd0, half_sel};
      LDST_W:  data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the single-cycle core's data port and a ready-handshake bus.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        access_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;

  logic        size_ok;
  logic        misalign;
  logic        err;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] ext;

  lsu_load_extract u_extract (
    .rdata_i (rdata_q),
    .off_i   (off_q),
    .size_i  (size_q),
    .data_o  (ext)
  );

  // Request legality check and store lane mapping from the core's inputs
  always_comb begin
    size_ok  = 1'b1;
    misalign = 1'b0;
    be_c     = 4'b1111;
    wd_c     = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        be_c = 4'b0001 << core_addr_i[1:0];
        wd_c = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        misalign = core_addr_i[0];
        be_c     = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_c     = {2{core_wd_i[15:0]}};
      end
      LDST_W:  misalign = |core_addr_i[1:0];
      default: size_ok = 1'b0;
    endcase
    if (!core_we_i) be_c = 4'b1111;
    err = core_req_i && (!size_ok || misalign);
  end

  assign access_err_o = err;

  // Next-state logic and bus/core outputs; IDLE drives the bus straight from the
  // core, the other states from the copy latched at acceptance (identical while
  // the core holds its inputs, and still valid after a trap drops the request)
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    off_d        = off_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    be_d         = be_q;
    we_d         = we_q;
    mem_req_o    = 1'b0;
    core_stall_o = 1'b0;
    mem_we_o     = we_q;
    mem_be_o     = be_q;
    mem_addr_o   = addr_q;
    mem_wd_o     = wd_q;
    core_rd_o    = '0;
    case (state_q)
      IDLE: begin
        mem_we_o   = core_we_i;
        mem_be_o   = be_c;
        mem_addr_o = {core_addr_i[31:2], 2'b00};
        mem_wd_o   = wd_c;
        if (core_req_i && !err) begin
          mem_req_o    = 1'b1;
          core_stall_o = 1'b1;
          off_d        = core_addr_i[1:0];
          size_d       = core_size_i;
          addr_d       = {core_addr_i[31:2], 2'b00};
          we_d         = core_we_i;
          be_d         = be_c;
          wd_d         = wd_c;
          if (mem_ready_i) begin
            rdata_d = mem_rd_i;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req_o    = 1'b1;
        core_stall_o = 1'b1;
        // a trap dropping the request never aborts the bus; a ready landing in
        // the same cycle already completes it, so skip DRAIN in that case
        if (!core_req_i) begin
          state_d = mem_ready_i ? IDLE : DRAIN;
        end else if (mem_ready_i) begin
          rdata_d = mem_rd_i;
          state_d = DONE;
        end
      end
      DRAIN: begin
        mem_req_o    = 1'b1;
        core_stall_o = 1'b1;
        if (mem_ready_i) state_d = IDLE;
      end
      DONE: begin
        core_rd_o = ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: table-driven accesses plus hand-written multi-cycle sequences.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd;
  logic [31:0] core_rd;
  logic        core_stall, access_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  lsu dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .access_err_o (access_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (ready)
  );

  // Bus memory model: read data only meaningful with ready, garbage otherwise
  assign mem_rd = ready ? mem[mem_addr[9:2]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16] <= 32'h80F0_1234;
    end else if (mem_req && mem_we && ready) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    int unsigned lat;
    logic        err;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_access(input vec_t v, input int idx);
    string tag;
    int    stalls;
    tag       = $sformatf("v%0d", idx);
    core_req  = 1'b1;
    core_we   = v.we;
    core_size = v.size;
    core_addr = v.addr;
    core_wd   = v.wd;
    ready     = (v.lat == 0);
    smp();
    chk({tag, "_err"}, {31'd0, access_err}, {31'd0, v.err});
    if (v.err) begin
      chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_stall"}, {31'd0, core_stall}, 32'd0);
      cyc();
      core_req = 1'b0;
      ready    = 1'b0;
      smp();
      chk({tag, "_stay_idle"}, {31'd0, mem_req}, 32'd0);
      cyc();
    end else begin
      chk({tag, "_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, v.we});
      chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, v.be});
      if (v.we) chk({tag, "_wd"}, mem_wd, v.bwd);
      stalls = 0;
      for (int c = 0; c < 20; c++) begin
        if (core_stall !== 1'b1) break;
        stalls++;
        cyc();
        ready = (c + 1 >= v.lat);
        smp();
      end
      chk({tag, "_stall_cycles"}, stalls, v.lat + 1);
      chk({tag, "_done_req"}, {31'd0, mem_req}, 32'd0);
      if (!v.we) chk({tag, "_rd"}, core_rd, v.rd);
      cyc();
      core_req = 1'b0;
      ready    = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    //          we    size     addr           wd             lat err be       bwd            rd
    vecs[0]  = '{1'b1, LDST_B,  32'h0000_0103, 32'hAABB_CCDD, 0, 1'b0, 4'b1000, 32'hDDDD_DDDD, 32'h0};
    vecs[1]  = '{1'b0, LDST_B,  32'h0000_0043, 32'h0,         3, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b0, LDST_BU, 32'h0000_0043, 32'h0,         3, 1'b0, 4'b1111, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b0, LDST_H,  32'h0000_0042, 32'h0,         3, 1'b0, 4'b1111, 32'h0,         32'hFFFF_80F0};
    vecs[4]  = '{1'b0, LDST_HU, 32'h0000_0040, 32'h0,         3, 1'b0, 4'b1111, 32'h0,         32'h0000_1234};
    vecs[5]  = '{1'b0, LDST_W,  32'h0000_0202, 32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, LDST_H,  32'h0000_0106, 32'h1234_ABCD, 1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[7]  = '{1'b1, LDST_W,  32'h0000_0108, 32'h1122_3344, 2, 1'b0, 4'b1111, 32'h1122_3344, 32'h0};
    vecs[8]  = '{1'b0, LDST_B,  32'h0000_0041, 32'h0,         0, 1'b0, 4'b1111, 32'h0,         32'h0000_0012};
    vecs[9]  = '{1'b0, LDST_H,  32'h0000_0040, 32'h0,         1, 1'b0, 4'b1111, 32'h0,         32'h0000_1234};
    vecs[10] = '{1'b0, LDST_W,  32'h0000_0040, 32'h0,         0, 1'b0, 4'b1111, 32'h0,         32'h80F0_1234};
    vecs[11] = '{1'b0, 3'd3,    32'h0000_0040, 32'h0,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[12] = '{1'b1, LDST_H,  32'h0000_0101, 32'h0000_5555, 0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[13] = '{1'b0, LDST_W,  32'h0000_0100, 32'h0,         2, 1'b0, 4'b1111, 32'h0,         32'hDD00_0000};

    rst       = 1'b1;
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_size = LDST_W;
    core_addr = '0;
    core_wd   = '0;
    ready     = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    smp();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_rd", core_rd, 32'd0);
    chk("rst_err", {31'd0, access_err}, 32'd0);
    cyc();

    for (int i = 0; i < 14; i++) do_access(vecs[i], i);

    // Trap mid-access: request drops in WAIT, bus completes two cycles later
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = LDST_W;
    core_addr = 32'h0000_0040;
    ready     = 1'b0;
    smp();
    chk("trap_idle_req", {31'd0, mem_req}, 32'd1);
    chk("trap_idle_stall", {31'd0, core_stall}, 32'd1);
    cyc();
    core_req  = 1'b0;
    core_addr = 32'h0000_0FFC;
    smp();
    chk("trap_wait_req", {31'd0, mem_req}, 32'd1);
    chk("trap_wait_rd", core_rd, 32'd0);
    cyc();
    smp();
    chk("trap_drain1_req", {31'd0, mem_req}, 32'd1);
    chk("trap_drain1_stall", {31'd0, core_stall}, 32'd1);
    chk("trap_drain1_addr", mem_addr, 32'h0000_0040);
    chk("trap_drain1_rd", core_rd, 32'd0);
    cyc();
    ready = 1'b1;
    smp();
    chk("trap_drain2_req", {31'd0, mem_req}, 32'd1);
    chk("trap_drain2_stall", {31'd0, core_stall}, 32'd1);
    chk("trap_drain2_addr", mem_addr, 32'h0000_0040);
    chk("trap_drain2_rd", core_rd, 32'd0);
    cyc();
    ready = 1'b0;
    smp();
    chk("trap_after_req", {31'd0, mem_req}, 32'd0);
    chk("trap_after_stall", {31'd0, core_stall}, 32'd0);
    chk("trap_after_rd", core_rd, 32'd0);
    cyc();

    // Back-to-back SW then LW to the same word, ready always high
    core_req  = 1'b1;
    core_we   = 1'b1;
    core_size = LDST_W;
    core_addr = 32'h0000_0180;
    core_wd   = 32'hCAFE_F00D;
    ready     = 1'b1;
    smp();
    chk("b2b_sw_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_sw_stall", {31'd0, core_stall}, 32'd1);
    cyc();
    smp();
    chk("b2b_sw_done_req", {31'd0, mem_req}, 32'd0);
    chk("b2b_sw_done_stall", {31'd0, core_stall}, 32'd0);
    cyc();
    core_we = 1'b0;
    core_wd = '0;
    smp();
    chk("b2b_lw_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_lw_stall", {31'd0, core_stall}, 32'd1);
    cyc();
    smp();
    chk("b2b_lw_done_req", {31'd0, mem_req}, 32'd0);
    chk("b2b_lw_done_stall", {31'd0, core_stall}, 32'd0);
    chk("b2b_lw_rd", core_rd, 32'hCAFE_F00D);
    cyc();
    core_req = 1'b0;
    ready    = 1'b0;

    // Stray ready with no request outstanding
    ready = 1'b1;
    smp();
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_stall", {31'd0, core_stall}, 32'd0);
    cyc();
    ready = 1'b0;
    smp();
    chk("stray_next_rd", core_rd, 32'd0);
    chk("stray_next_stall", {31'd0, core_stall}, 32'd0);
    cyc();

    // Reset while waiting on the bus
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = LDST_W;
    core_addr = 32'h0000_0040;
    ready     = 1'b0;
    cyc();
    smp();
    chk("rstw_wait_req", {31'd0, mem_req}, 32'd1);
    rst      = 1'b1;
    core_req = 1'b0;
    cyc();
    smp();
    chk("rstw_req", {31'd0, mem_req}, 32'd0);
    chk("rstw_stall", {31'd0, core_stall}, 32'd0);
    chk("rstw_rd", core_rd, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
